// File: rtl/ase_mmio_pkg.sv
// Shared CCI-P MMIO types, CSR index map and length encodings.
// Includes the read-pipeline bundle used by ccip_mmio_responder.
package ase_mmio_pkg;

    localparam int CSR_IDX_DFH      = 0;
    localparam int CSR_IDX_AFU_ID_L = 1;
    localparam int CSR_IDX_AFU_ID_H = 2;
    localparam int CSR_IDX_RSVD     = 3;
    localparam int CSR_FIRST_RW     = 4;

    localparam logic [1:0] MMIO_LEN_4B   = 2'b00;
    localparam logic [1:0] MMIO_LEN_8B   = 2'b01;
    localparam logic [1:0] MMIO_LEN_64B  = 2'b10;
    localparam logic [1:0] MMIO_LEN_RSVD = 2'b11;

    typedef logic [26:0] t_ccip_c0_RspHdr;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_RspHdr hdr;
        logic [63:0]     data;
        logic            mmioWrValid;
        logic            mmioRdValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        logic        valid;
        logic [8:0]  tid;
        logic [14:0] idx;
        logic        half;
        logic [1:0]  len;
        logic        illegal;
    } t_mmio_rd_pipe;

endpackage

// File: rtl/ccip_mmio_decode.sv
// Combinational MMIO header decode: CSR index, dword half, legality.
// Shared by the read and write paths of ccip_mmio_responder.
module ccip_mmio_decode
    import ase_mmio_pkg::*;
#(
    parameter int NUM_CSRS = 16
) (
    input  t_ccip_c0_ReqMmioHdr hdr,
    output logic [14:0]         idx,
    output logic                half,
    output logic                legal
);

    logic len_ok;
    logic in_range;

    always_comb begin
        idx      = hdr.address[15:1];
        half     = hdr.address[0];
        in_range = int'(idx) < NUM_CSRS;
        len_ok   = (hdr.length == MMIO_LEN_4B) ||
                   ((hdr.length == MMIO_LEN_8B) && !half);
        legal    = in_range && len_ok;
    end

endmodule

// File: rtl/ccip_mmio_responder.sv
// CCI-P MMIO completer and CSR file with a two-stage read pipeline.
// Optional macro CCIP_MMIO_ERR_LOG_EN turns the top CSR into an error log.
module ccip_mmio_responder
    import ase_mmio_pkg::*;
#(
    parameter int          NUM_CSRS  = 16,
    parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_0000,
    parameter logic [63:0] AFU_ID_L  = 64'h0,
    parameter logic [63:0] AFU_ID_H  = 64'h0
) (
    input  logic                        clk,
    input  logic                        SoftReset,
    input  t_if_ccip_Rx                 ccip_rx,
    output t_if_ccip_c2_Tx              ccip_c2tx,
    output logic [NUM_CSRS*64-1:0]      csr_q,
    output logic [NUM_CSRS-1:0]         csr_wr_pulse,
    input  logic                        hw_wr_en,
    input  logic [$clog2(NUM_CSRS)-1:0] hw_wr_idx,
    input  logic [63:0]                 hw_wr_data
);

    localparam int IW = $clog2(NUM_CSRS);
`ifdef CCIP_MMIO_ERR_LOG_EN
    localparam int RW_LAST = NUM_CSRS - 2;
`else
    localparam int RW_LAST = NUM_CSRS - 1;
`endif

    t_ccip_c0_ReqMmioHdr hdr;
    logic [14:0]         dec_idx;
    logic                dec_half;
    logic                dec_legal;
    logic                wr_ok;

    logic [63:0]         regs_q [NUM_CSRS];
    logic [63:0]         regs_d [NUM_CSRS];
    logic [NUM_CSRS-1:0] pulse_q, pulse_d;
    t_mmio_rd_pipe       rd_s1_q, rd_s1_d;
    t_if_ccip_c2_Tx      c2_q, c2_d;
    logic [63:0]         rd_word;

    assign hdr = t_ccip_c0_ReqMmioHdr'(ccip_rx.c0.hdr);

    ccip_mmio_decode #(.NUM_CSRS(NUM_CSRS)) u_dec (
        .hdr   (hdr),
        .idx   (dec_idx),
        .half  (dec_half),
        .legal (dec_legal)
    );

    assign wr_ok = ccip_rx.c0.mmioWrValid && dec_legal;

`ifdef CCIP_MMIO_ERR_LOG_EN
    logic [31:0] err_cnt_q, err_cnt_d;
    logic [15:0] err_addr_q, err_addr_d;
    logic        illegal_ev;

    // A read colliding with a write is dropped and logged as illegal
    always_comb begin
        illegal_ev = (ccip_rx.c0.mmioWrValid && !dec_legal) ||
                     (ccip_rx.c0.mmioRdValid &&
                      (!dec_legal || ccip_rx.c0.mmioWrValid));
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        if (illegal_ev) begin
            if (err_cnt_q != 32'hFFFF_FFFF)
                err_cnt_d = err_cnt_q + 32'd1;
            err_addr_d = hdr.address;
        end
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end
`endif

    // CSR update: hardware port first so an MMIO write to the same index wins
    always_comb begin
        for (int i = 0; i < NUM_CSRS; i++)
            regs_d[i] = regs_q[i];
        pulse_d = '0;
        regs_d[CSR_IDX_DFH]      = DFH_VALUE;
        regs_d[CSR_IDX_AFU_ID_L] = AFU_ID_L;
        regs_d[CSR_IDX_AFU_ID_H] = AFU_ID_H;
        regs_d[CSR_IDX_RSVD]     = '0;
        for (int i = CSR_FIRST_RW; i <= RW_LAST; i++) begin
            if (hw_wr_en && (hw_wr_idx == IW'(i)))
                regs_d[i] = hw_wr_data;
            if (wr_ok && (dec_idx == 15'(i))) begin
                pulse_d[i] = 1'b1;
                if (hdr.length == MMIO_LEN_8B)
                    regs_d[i] = ccip_rx.c0.data;
                else if (dec_half)
                    regs_d[i][63:32] = ccip_rx.c0.data[31:0];
                else
                    regs_d[i][31:0] = ccip_rx.c0.data[31:0];
            end
        end
`ifdef CCIP_MMIO_ERR_LOG_EN
        regs_d[NUM_CSRS-1] = {16'h0, err_addr_d, err_cnt_d};
`endif
    end

    always_comb begin
        rd_s1_d.valid   = ccip_rx.c0.mmioRdValid &&
                          !ccip_rx.c0.mmioWrValid;
        rd_s1_d.tid     = hdr.tid;
        rd_s1_d.idx     = dec_idx;
        rd_s1_d.half    = dec_half;
        rd_s1_d.len     = hdr.length;
        rd_s1_d.illegal = !dec_legal;
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_CSRS; i++)
            if (rd_s1_q.idx == 15'(i))
                rd_word = regs_q[i];
        c2_d.mmioRdValid = rd_s1_q.valid;
        c2_d.hdr.tid     = rd_s1_q.tid;
        c2_d.data        = '0;
        if (rd_s1_q.valid && !rd_s1_q.illegal) begin
            if (rd_s1_q.len == MMIO_LEN_8B)
                c2_d.data = rd_word;
            else if (rd_s1_q.half)
                c2_d.data = {32'h0, rd_word[63:32]};
            else
                c2_d.data = {32'h0, rd_word[31:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            for (int i = 0; i < NUM_CSRS; i++)
                regs_q[i] <= '0;
            regs_q[CSR_IDX_DFH]      <= DFH_VALUE;
            regs_q[CSR_IDX_AFU_ID_L] <= AFU_ID_L;
            regs_q[CSR_IDX_AFU_ID_H] <= AFU_ID_H;
            pulse_q <= '0;
            rd_s1_q <= '0;
            c2_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CSRS; i++)
                regs_q[i] <= regs_d[i];
            pulse_q <= pulse_d;
            rd_s1_q <= rd_s1_d;
            c2_q    <= c2_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CSRS; i++)
            csr_q[64*i +: 64] = regs_q[i];
    end

    assign csr_wr_pulse = pulse_q;
    assign ccip_c2tx    = c2_q;

endmodule

// File: tb/tb_ccip_mmio_responder.sv
// Directed self-checking bench for ccip_mmio_responder.
module tb_ccip_mmio_responder;
    import ase_mmio_pkg::*;

    localparam int          N    = 16;
    localparam logic [63:0] DFH  = 64'h1000_0000_0000_0000;
    localparam logic [63:0] IDL  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] IDH  = 64'hFEDC_BA98_7654_3210;
    localparam logic [1:0]  L4   = 2'b00;
    localparam logic [1:0]  L8   = 2'b01;
    localparam logic [1:0]  L64  = 2'b10;

    logic           clk = 1'b0;
    logic           SoftReset;
    t_if_ccip_Rx    rx;
    t_if_ccip_c2_Tx c2;
    logic [N*64-1:0] csr;
    logic [N-1:0]   pulse;
    logic           hw_en;
    logic [3:0]     hw_idx;
    logic [63:0]    hw_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [8:0]  tid;
        logic [63:0] data;
    } rsp_t;
    rsp_t rspq[$];

    always #5 clk = ~clk;

    ccip_mmio_responder #(
        .NUM_CSRS  (N),
        .DFH_VALUE (DFH),
        .AFU_ID_L  (IDL),
        .AFU_ID_H  (IDH)
    ) dut (
        .clk          (clk),
        .SoftReset    (SoftReset),
        .ccip_rx      (rx),
        .ccip_c2tx    (c2),
        .csr_q        (csr),
        .csr_wr_pulse (pulse),
        .hw_wr_en     (hw_en),
        .hw_wr_idx    (hw_idx),
        .hw_wr_data   (hw_data)
    );

    always @(posedge clk) begin
        rsp_t r;
        cyc++;
        #1;
        if (c2.mmioRdValid) begin
            r.cyc  = cyc;
            r.tid  = c2.hdr.tid;
            r.data = c2.data;
            rspq.push_back(r);
        end
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic t_ccip_c0_RspHdr mk(logic [15:0] a, logic [1:0] len,
                                          logic [8:0] tid);
        t_ccip_c0_ReqMmioHdr h;
        h.address = a;
        h.length  = len;
        h.tid     = tid;
        return t_ccip_c0_RspHdr'(h);
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [1:0] len, input logic [8:0] tid,
                         input logic [63:0] d, output int c);
        @(negedge clk);
        rx.c0.mmioRdValid = rd;
        rx.c0.mmioWrValid = wr;
        rx.c0.hdr         = mk(a, len, tid);
        rx.c0.data        = d;
        @(posedge clk);
        #1;
        c = cyc;
    endtask

    task automatic idle();
        @(negedge clk);
        rx.c0.mmioRdValid = 1'b0;
        rx.c0.mmioWrValid = 1'b0;
    endtask

    task automatic rd1(input logic [15:0] a, input logic [1:0] len,
                       input logic [8:0] tid, output int c);
        drive(1'b1, 1'b0, a, len, tid, 64'h0, c);
        idle();
    endtask

    task automatic get_rsp(string tag, logic [8:0] tid, logic [63:0] data,
                           int exp_cyc);
        rsp_t r;
        int   n = 0;
        while (rspq.size() == 0 && n < 8) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (rspq.size() == 0) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            r = rspq.pop_front();
            check({tag, "_tid"}, 64'(r.tid), 64'(tid));
            check({tag, "_data"}, r.data, data);
            if (exp_cyc >= 0)
                check({tag, "_lat"}, 64'(r.cyc), 64'(exp_cyc));
        end
    endtask

    int c, cb[4];
    logic [63:0] b2b_exp[4];
    logic [63:0] log_exp;

    initial begin
        SoftReset = 1'b1;
        rx        = '0;
        hw_en     = 1'b0;
        hw_idx    = '0;
        hw_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(c2.mmioRdValid), 64'd0);
        check("rst_data", c2.data, 64'd0);
        check("rst_pulse", 64'(pulse), 64'd0);
        check("rst_csr4", csr[4*64 +: 64], 64'd0);
        check("rst_csr0", csr[0 +: 64], DFH);
        @(negedge clk);
        SoftReset = 1'b0;

        rd1(16'h0000, L8, 9'h012, c);
        get_rsp("rd_dfh", 9'h012, DFH, c + 1);
        rd1(16'h0002, L8, 9'h013, c);
        get_rsp("rd_idl", 9'h013, IDL, c + 1);
        rd1(16'h0004, L8, 9'h014, c);
        get_rsp("rd_idh", 9'h014, IDH, c + 1);
        rd1(16'h0006, L8, 9'h015, c);
        get_rsp("rd_rsvd", 9'h015, 64'd0, c + 1);

        drive(1'b0, 1'b1, 16'h0008, L8, 9'h0, 64'hDEAD_BEEF_CAFE_F00D, c);
        check("wr_pulse", 64'(pulse), 64'h10);
        drive(1'b1, 1'b0, 16'h0008, L8, 9'h016, 64'h0, c);
        check("pulse_1cyc", 64'(pulse), 64'h0);
        idle();
        get_rsp("raw8", 9'h016, 64'hDEAD_BEEF_CAFE_F00D, c + 1);

        drive(1'b0, 1'b1, 16'h0009, L4, 9'h0, 64'h5A5A_5A5A_1122_3344, c);
        drive(1'b1, 1'b0, 16'h0009, L4, 9'h017, 64'h0, c);
        idle();
        get_rsp("rd4_hi", 9'h017, 64'h0000_0000_1122_3344, c + 1);
        rd1(16'h0008, L8, 9'h018, c);
        get_rsp("rd8_mix", 9'h018, 64'h1122_3344_CAFE_F00D, c + 1);
        rd1(16'h0008, L4, 9'h019, c);
        get_rsp("rd4_lo", 9'h019, 64'h0000_0000_CAFE_F00D, c + 1);

        b2b_exp[0] = 64'h1122_3344_CAFE_F00D;
        b2b_exp[1] = DFH;
        b2b_exp[2] = IDL;
        b2b_exp[3] = IDH;
        drive(1'b1, 1'b0, 16'h0008, L8, 9'd1, 64'h0, cb[0]);
        drive(1'b1, 1'b0, 16'h0000, L8, 9'd2, 64'h0, cb[1]);
        drive(1'b1, 1'b0, 16'h0002, L8, 9'd3, 64'h0, cb[2]);
        drive(1'b1, 1'b0, 16'h0004, L8, 9'd4, 64'h0, cb[3]);
        idle();
        for (int i = 0; i < 4; i++)
            get_rsp("b2b", 9'(i + 1), b2b_exp[i], cb[0] + 1 + i);

        rd1(16'h0009, L8, 9'h021, c);
        get_rsp("ill_8b_odd", 9'h021, 64'd0, c + 1);
        rd1(16'h0008, L64, 9'h022, c);
        get_rsp("ill_64b", 9'h022, 64'd0, c + 1);
        rd1(16'h0020, L8, 9'h023, c);
        get_rsp("ill_range", 9'h023, 64'd0, c + 1);
`ifdef CCIP_MMIO_ERR_LOG_EN
        log_exp = 64'h0000_0020_0000_0003;
`else
        log_exp = 64'd0;
`endif
        rd1(16'h001E, L8, 9'h024, c);
        get_rsp("top_csr", 9'h024, log_exp, c + 1);

        drive(1'b0, 1'b1, 16'h0000, L8, 9'h0, 64'hFFFF_0000_FFFF_0000, c);
        check("ro_nopulse", 64'(pulse), 64'h0);
        idle();
        rd1(16'h0000, L8, 9'h025, c);
        get_rsp("ro_keep", 9'h025, DFH, c + 1);
        drive(1'b0, 1'b1, 16'h0009, L8, 9'h0, 64'h5555_5555_5555_5555, c);
        check("illwr_pulse", 64'(pulse), 64'h0);
        check("illwr_drop", csr[4*64 +: 64], 64'h1122_3344_CAFE_F00D);
        idle();

        hw_en   = 1'b1;
        hw_idx  = 4'd5;
        hw_data = 64'hAA;
        drive(1'b0, 1'b1, 16'h000A, L8, 9'h0, 64'hBB, c);
        check("collide", csr[5*64 +: 64], 64'hBB);
        hw_idx  = 4'd6;
        hw_data = 64'h77;
        idle();
        @(posedge clk);
        #1;
        check("hw_wr", csr[6*64 +: 64], 64'h77);
        check("hw_nopulse", 64'(pulse), 64'h0);
        hw_idx  = 4'd2;
        hw_data = 64'h1234;
        @(posedge clk);
        #1;
        hw_en = 1'b0;
        check("hw_ro", csr[2*64 +: 64], IDH);

        drive(1'b1, 1'b1, 16'h000E, L8, 9'h026, 64'h99, c);
        idle();
        repeat (4) @(posedge clk);
        #2;
        check("both_norsp", 64'(rspq.size()), 64'd0);
        check("both_wr", csr[7*64 +: 64], 64'h99);

        drive(1'b1, 1'b0, 16'h0008, L8, 9'h055, 64'h0, c);
        @(negedge clk);
        rx.c0.mmioRdValid = 1'b0;
        SoftReset = 1'b1;
        @(negedge clk);
        SoftReset = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("rst_flush", 64'(rspq.size()), 64'd0);
        check("rst_clr4", csr[4*64 +: 64], 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
